// File: rtl/multiword_adder_ctrl_if.sv
// Request/result bundle for multiword_adder_ctrl: operand handshake in, result handshake out.
// iSub exists only when MULTIWORD_ADDER_SUB_EN is defined.
interface multiword_adder_ctrl_if #(
  parameter int TW = 64
);
  logic          iValid;
  logic          oReady;
  logic [TW-1:0] iA;
  logic [TW-1:0] iB;
  logic          iC;
`ifdef MULTIWORD_ADDER_SUB_EN
  logic          iSub;
`endif
  logic          oValid;
  logic          iReady;
  logic [TW-1:0] oS;
  logic          oC;
  logic          oBusy;

`ifdef MULTIWORD_ADDER_SUB_EN
  modport slave (
    input  iValid, iA, iB, iC, iSub, iReady,
    output oReady, oValid, oS, oC, oBusy
  );
  modport master (
    output iValid, iA, iB, iC, iSub, iReady,
    input  oReady, oValid, oS, oC, oBusy
  );
`else
  modport slave (
    input  iValid, iA, iB, iC, iReady,
    output oReady, oValid, oS, oC, oBusy
  );
  modport master (
    output iValid, iA, iB, iC, iReady,
    input  oReady, oValid, oS, oC, oBusy
  );
`endif
endinterface

// File: rtl/multiword_adder_ctrl.sv
// Wide adder built from one WIDTH-bit carry-select/lookahead adder reused once per word.
// Optional subtract mode (B inverted, carry-in forced to 1) when MULTIWORD_ADDER_SUB_EN is defined.

module giulio_fast_adder #(
  parameter int WIDTH       = 16,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic [WIDTH-1:0] oS,
  output logic             oC
);
  localparam int NBLK = WIDTH / BLOCK_WIDTH;

  logic                   blk_cin;
  logic [BLOCK_WIDTH-1:0] blk_g;
  logic [BLOCK_WIDTH-1:0] blk_p;
  logic [BLOCK_WIDTH:0]   blk_c0;
  logic [BLOCK_WIDTH:0]   blk_c1;

  // Each block precomputes both carry-in cases; the incoming block carry only picks one.
  always_comb begin
    blk_cin = iC;
    blk_g   = '0;
    blk_p   = '0;
    blk_c0  = '0;
    blk_c1  = '0;
    oS      = '0;
    for (int k = 0; k < NBLK; k++) begin
      blk_g     = iA[k*BLOCK_WIDTH +: BLOCK_WIDTH] & iB[k*BLOCK_WIDTH +: BLOCK_WIDTH];
      blk_p     = iA[k*BLOCK_WIDTH +: BLOCK_WIDTH] ^ iB[k*BLOCK_WIDTH +: BLOCK_WIDTH];
      blk_c0    = '0;
      blk_c1    = '0;
      blk_c1[0] = 1'b1;
      for (int i = 0; i < BLOCK_WIDTH; i++) begin
        blk_c0[i+1] = blk_g[i] | (blk_p[i] & blk_c0[i]);
        blk_c1[i+1] = blk_g[i] | (blk_p[i] & blk_c1[i]);
      end
      oS[k*BLOCK_WIDTH +: BLOCK_WIDTH] =
        blk_p ^ (blk_cin ? blk_c1[BLOCK_WIDTH-1:0] : blk_c0[BLOCK_WIDTH-1:0]);
      blk_cin = blk_cin ? blk_c1[BLOCK_WIDTH] : blk_c0[BLOCK_WIDTH];
    end
    oC = blk_cin;
  end
endmodule

module multiword_adder_ctrl #(
  parameter int WIDTH       = 16,
  parameter int BLOCK_WIDTH = 4,
  parameter int WORDS       = 4
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  multiword_adder_ctrl_if.slave bus
);
  localparam int TW    = WIDTH * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [TW-1:0]     a_q, a_d;
  logic [TW-1:0]     b_q, b_d;
  logic [TW-1:0]     acc_q, acc_d;
  logic [TW-1:0]     res_s_q, res_s_d;
  logic              res_c_q, res_c_d;
`ifdef MULTIWORD_ADDER_SUB_EN
  logic              sub_q, sub_d;
`endif

  logic [WIDTH-1:0]  add_a;
  logic [WIDTH-1:0]  add_b;
  logic [WIDTH-1:0]  add_s;
  logic              add_co;

  always_comb begin
    add_a = a_q[cnt_q*WIDTH +: WIDTH];
`ifdef MULTIWORD_ADDER_SUB_EN
    add_b = b_q[cnt_q*WIDTH +: WIDTH] ^ {WIDTH{sub_q}};
`else
    add_b = b_q[cnt_q*WIDTH +: WIDTH];
`endif
  end

  giulio_fast_adder #(
    .WIDTH       (WIDTH),
    .BLOCK_WIDTH (BLOCK_WIDTH)
  ) u_adder (
    .iA (add_a),
    .iB (add_b),
    .iC (carry_q),
    .oS (add_s),
    .oC (add_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_s_d = res_s_q;
    res_c_d = res_c_q;
`ifdef MULTIWORD_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.iValid) begin
          a_d     = bus.iA;
          b_d     = bus.iB;
          carry_d = bus.iC;
          cnt_d   = '0;
          state_d = RUN;
`ifdef MULTIWORD_ADDER_SUB_EN
          sub_d   = bus.iSub;
          if (bus.iSub) begin
            carry_d = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        acc_d[cnt_q*WIDTH +: WIDTH] = add_s;
        carry_d = add_co;
        // The last word publishes the assembled sum in the same edge it is written.
        if (cnt_q == LAST_WORD) begin
          res_s_d = acc_d;
          res_c_d = add_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.iReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_s_q <= '0;
      res_c_q <= 1'b0;
`ifdef MULTIWORD_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_s_q <= res_s_d;
      res_c_q <= res_c_d;
`ifdef MULTIWORD_ADDER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign bus.oReady = (state_q == IDLE);
  assign bus.oValid = (state_q == DONE);
  assign bus.oBusy  = (state_q != IDLE);
  assign bus.oS     = res_s_q;
  assign bus.oC     = res_c_q;
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Scoreboard bench for multiword_adder_ctrl: driver pushes reference results, monitor pops on handshake.
// Subtract cases are exercised when MULTIWORD_ADDER_SUB_EN is defined.
module tb_multiword_adder_ctrl;
  localparam int WIDTH       = 16;
  localparam int BLOCK_WIDTH = 4;
  localparam int WORDS       = 4;
  localparam int TW          = WIDTH * WORDS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multiword_adder_ctrl_if #(.TW(TW)) bus ();

  multiword_adder_ctrl #(
    .WIDTH       (WIDTH),
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .WORDS       (WORDS)
  ) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [TW-1:0] s;
    logic          c;
  } res_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   auto_ready = 1'b1;
  bit   force_ready = 1'b0;

  function automatic res_t model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                 input logic cin, input logic sub);
    logic [TW:0] t;
    if (sub) t = {1'b0, a} + {1'b0, ~b} + (TW+1)'(1);
    else     t = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
    return {t[TW-1:0], t[TW]};
  endfunction

  function automatic logic [TW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic chkw(input string name, input logic [TW:0] act, input logic [TW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: picks iReady before each edge and scores every result handshake.
  initial begin
    res_t e;
    bus.iReady = 1'b0;
    forever begin
      @(negedge clk);
      bus.iReady = auto_ready ? ($urandom_range(0, 3) != 0) : force_ready;
      if (rst_n === 1'b1 && bus.oValid === 1'b1 && bus.iReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got oS=%h oC=%b, expected no result", bus.oS, bus.oC);
        end else begin
          e = exp_q.pop_front();
          chkw("result", {bus.oS, bus.oC}, {e.s, e.c});
        end
      end
    end
  end

  task automatic issue(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                       input logic sub, input bit push);
    int n = 0;
    while (bus.oReady !== 1'b1) begin
      if (n == 60) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: got oReady=%b for %0d cycles, expected 1", bus.oReady, n);
        return;
      end
      bus.iA = rnd();
      bus.iB = rnd();
      bus.iC = 1'($urandom);
      cyc();
      n++;
    end
    bus.iValid = 1'b1;
    bus.iA     = a;
    bus.iB     = b;
    bus.iC     = cin;
`ifdef MULTIWORD_ADDER_SUB_EN
    bus.iSub   = sub;
`endif
    if (push) exp_q.push_back(model(a, b, cin, sub));
    cyc();
    bus.iValid = 1'b0;
    bus.iA     = rnd();
    bus.iB     = rnd();
    bus.iC     = 1'($urandom);
`ifdef MULTIWORD_ADDER_SUB_EN
    bus.iSub   = 1'($urandom);
`endif
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.oReady !== 1'b1) && n < 200) begin
      cyc();
      n++;
    end
    if (n == 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    logic [TW-1:0] a, b;
    logic          c, s;
    res_t          e1;
    int            lat;

    bus.iValid = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iC     = 1'b0;
`ifdef MULTIWORD_ADDER_SUB_EN
    bus.iSub   = 1'b0;
`endif
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_oReady", bus.oReady, 1'b1);
    chk1("rst_oValid", bus.oValid, 1'b0);
    chk1("rst_oBusy",  bus.oBusy,  1'b0);
    chkw("rst_oS_oC",  {bus.oS, bus.oC}, '0);
    rst_n = 1'b1;
    cyc();

    // Carry through every word, plus latency measurement.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
    lat = 0;
    while (bus.oValid !== 1'b1 && lat < 20) begin
      cyc();
      lat++;
    end
    chkw("latency", (TW+1)'(lat), (TW+1)'(WORDS));

    issue(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, 1'b1);

    // Backpressure with a competing request held on the bus.
    drain();
    auto_ready  = 1'b0;
    force_ready = 1'b0;
    a = rnd(); b = rnd(); c = 1'($urandom);
    e1 = model(a, b, c, 1'b0);
    issue(a, b, c, 1'b0, 1'b1);
    lat = 0;
    while (bus.oValid !== 1'b1 && lat < 20) begin
      cyc();
      lat++;
    end
    a = rnd(); b = rnd(); c = 1'($urandom);
    bus.iValid = 1'b1;
    bus.iA = a;
    bus.iB = b;
    bus.iC = c;
`ifdef MULTIWORD_ADDER_SUB_EN
    bus.iSub = 1'b0;
`endif
    for (int i = 0; i < 5; i++) begin
      chk1("hold_oValid", bus.oValid, 1'b1);
      chk1("hold_oReady", bus.oReady, 1'b0);
      chkw("hold_result", {bus.oS, bus.oC}, {e1.s, e1.c});
      cyc();
    end
    chkw("hold_result_end", {bus.oS, bus.oC}, {e1.s, e1.c});
    force_ready = 1'b1;
    cyc();
    chk1("after_hs_oReady", bus.oReady, 1'b1);
    chk1("after_hs_oValid", bus.oValid, 1'b0);
    exp_q.push_back(model(a, b, c, 1'b0));
    cyc();
    chk1("next_accept_oBusy",  bus.oBusy,  1'b1);
    chk1("next_accept_oReady", bus.oReady, 1'b0);
    bus.iValid = 1'b0;
    auto_ready = 1'b1;

    // Asynchronous reset two cycles into RUN discards the operation.
    drain();
    issue(rnd(), rnd(), 1'b1, 1'b0, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk1("arst_oValid", bus.oValid, 1'b0);
    chk1("arst_oBusy",  bus.oBusy,  1'b0);
    chk1("arst_oReady", bus.oReady, 1'b1);
    chkw("arst_oS_oC",  {bus.oS, bus.oC}, '0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < WORDS + 4; i++) begin
      chk1("post_rst_no_valid", bus.oValid, 1'b0);
      cyc();
    end

    // Randomized traffic with long carry chains mixed in.
    for (int i = 0; i < 40; i++) begin
      a = rnd();
      b = ($urandom_range(0, 3) == 0) ? ~a : rnd();
      c = 1'($urandom);
      s = 1'b0;
`ifdef MULTIWORD_ADDER_SUB_EN
      s = 1'($urandom);
`endif
      issue(a, b, c, s, 1'b1);
    end
    issue('0, '0, 1'b0, 1'b0, 1'b1);
    issue('1, '1, 1'b1, 1'b0, 1'b1);

`ifdef MULTIWORD_ADDER_SUB_EN
    issue(64'd5, 64'd7, 1'b0, 1'b1, 1'b1);
    issue(64'd7, 64'd5, 1'b0, 1'b1, 1'b1);
    issue(64'd7, 64'd5, 1'b1, 1'b1, 1'b1);
`endif

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
